// File: rtl/jtcps1_vram_rdslot_if.sv
// VRAM read bus (palette copy engine side) plus the 32-bit SDRAM read port behind it.
// The slave modport is the read-slot view; the master modport is the requester/arbiter side.
interface jtcps1_vram_rdslot_if;
  logic        vram_cs;
  logic [17:0] vram_addr;
  logic [15:0] vram_data;
  logic        vram_ok;
  logic        cache_inv;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        sdram_rdy;
  logic [31:0] sdram_din;

  modport slave (
    input  vram_cs, vram_addr, cache_inv, sdram_ack, sdram_rdy, sdram_din,
    output vram_data, vram_ok, sdram_addr, sdram_req
  );

  modport master (
    output vram_cs, vram_addr, cache_inv, sdram_ack, sdram_rdy, sdram_din,
    input  vram_data, vram_ok, sdram_addr, sdram_req
  );
endinterface

// File: rtl/jtcps1_vram_rdslot.sv
// VRAM read slot: serves 16-bit VRAM reads from a one-line (two-word) cache
// refilled through a 32-bit SDRAM read port. Fetches are never aborted.
module jtcps1_vram_rdslot #(
  parameter logic [21:0] VRAM_OFFSET = 22'h10_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  jtcps1_vram_rdslot_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      state_q,      state_d;
  logic [17:0] addr_l_q,     addr_l_d;
  logic [31:0] line_q,       line_d;
  logic [16:0] tag_q,        tag_d;
  logic [16:0] ftag_q,       ftag_d;
  logic        valid_q,      valid_d;
  logic        inv_seen_q,   inv_seen_d;
  logic [15:0] vram_data_q,  vram_data_d;
  logic        vram_ok_q,    vram_ok_d;
  logic        sdram_req_q,  sdram_req_d;
  logic [21:0] sdram_addr_q, sdram_addr_d;

  logic hit;
  logic addr_match;
  logic issue;
  logic fill;

  // hit and match both look at the registered address, so any vram_addr
  // change forces vram_ok low for one cycle before fresh data is shown
  always_comb begin
    hit        = valid_q && (tag_q == addr_l_q[17:1]);
    addr_match = (bus.vram_addr == addr_l_q);
    addr_l_d   = bus.vram_addr;
    vram_ok_d  = bus.vram_cs && addr_match && hit;
    vram_data_d = vram_data_q;
    if (vram_ok_d)
      vram_data_d = addr_l_q[0] ? line_q[31:16] : line_q[15:0];
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.vram_cs && addr_match && !hit) state_d = ST_REQ;
      ST_REQ:  if (bus.sdram_ack) state_d = bus.sdram_rdy ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (bus.sdram_rdy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // datapath / outputs
  always_comb begin
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    ftag_d       = ftag_q;
    inv_seen_d   = inv_seen_q;
    line_d       = line_q;
    tag_d        = tag_q;
    valid_d      = valid_q;

    issue = (state_q == ST_IDLE) && (state_d == ST_REQ);
    // ack+rdy together while in REQ counts as ack then rdy
    fill  = ((state_q == ST_REQ)  && bus.sdram_ack && bus.sdram_rdy) ||
            ((state_q == ST_WAIT) && bus.sdram_rdy);

    if (issue) begin
      sdram_req_d  = 1'b1;
      sdram_addr_d = VRAM_OFFSET + {4'd0, addr_l_q[17:1], 1'b0};
      ftag_d       = addr_l_q[17:1];
      inv_seen_d   = 1'b0;
    end

    if ((state_q == ST_REQ) && bus.sdram_ack)
      sdram_req_d = 1'b0;

    // an invalidate during a fetch taints the line that is still on its way
    if (bus.cache_inv) begin
      valid_d = 1'b0;
      if (state_q != ST_IDLE) inv_seen_d = 1'b1;
    end

    if (fill) begin
      line_d  = bus.sdram_din;
      tag_d   = ftag_q;
      valid_d = !inv_seen_q && !bus.cache_inv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_l_q     <= '0;
      line_q       <= '0;
      tag_q        <= '0;
      ftag_q       <= '0;
      valid_q      <= 1'b0;
      inv_seen_q   <= 1'b0;
      vram_data_q  <= '0;
      vram_ok_q    <= 1'b0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
    end else begin
      addr_l_q     <= addr_l_d;
      line_q       <= line_d;
      tag_q        <= tag_d;
      ftag_q       <= ftag_d;
      valid_q      <= valid_d;
      inv_seen_q   <= inv_seen_d;
      vram_data_q  <= vram_data_d;
      vram_ok_q    <= vram_ok_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
    end
  end

  assign bus.vram_data  = vram_data_q;
  assign bus.vram_ok    = vram_ok_q;
  assign bus.sdram_req  = sdram_req_q;
  assign bus.sdram_addr = sdram_addr_q;

endmodule

// File: tb/tb_jtcps1_vram_rdslot.sv
// Directed bench for jtcps1_vram_rdslot: miss/hit, coincident ack+rdy, mid-fetch
// address change, invalidation, async reset, address wrap and a 4096-word sweep.
module tb_jtcps1_vram_rdslot;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  int   nreq = 0;
  logic req_prev = 1'b0;
  int   base;

  always #5 clk = ~clk;

  jtcps1_vram_rdslot_if u_if ();
  jtcps1_vram_rdslot_if w_if ();

  jtcps1_vram_rdslot dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  jtcps1_vram_rdslot #(.VRAM_OFFSET(22'h3F_FFFE)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (w_if.slave)
  );

  // rising edges of sdram_req on the main instance
  always @(negedge clk) begin
    if (u_if.sdram_req && !req_prev) nreq <= nreq + 1;
    req_prev <= u_if.sdram_req;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mw(input int a);
    return 16'(a * 40503) ^ 16'h1357;
  endfunction

  task automatic wait_req(input logic [21:0] exp_addr);
    int n = 0;
    while (u_if.sdram_req !== 1'b1 && n < 32) begin step(); n++; end
    chk("req_seen", 32'(u_if.sdram_req), 32'd1);
    chk("req_addr", 32'(u_if.sdram_addr), 32'(exp_addr));
  endtask

  task automatic do_ack(input int dly, input bit with_rdy, input logic [31:0] din);
    repeat (dly) step();
    chk("req_hold", 32'(u_if.sdram_req), 32'd1);
    u_if.sdram_ack = 1'b1;
    if (with_rdy) begin u_if.sdram_rdy = 1'b1; u_if.sdram_din = din; end
    step();
    u_if.sdram_ack = 1'b0;
    u_if.sdram_rdy = 1'b0;
    chk("req_drop", 32'(u_if.sdram_req), 32'd0);
  endtask

  task automatic do_rdy(input int dly, input bit inv, input logic [31:0] din);
    repeat (dly) step();
    u_if.sdram_rdy = 1'b1;
    u_if.sdram_din = din;
    u_if.cache_inv = inv;
    step();
    u_if.sdram_rdy = 1'b0;
    u_if.cache_inv = 1'b0;
  endtask

  task automatic wait_ok(input string tag, input logic [15:0] exp);
    int n = 0;
    while (u_if.vram_ok !== 1'b1 && n < 32) begin step(); n++; end
    chk({tag, "_ok"}, 32'(u_if.vram_ok), 32'd1);
    chk(tag, 32'(u_if.vram_data), 32'(exp));
  endtask

  initial begin
    u_if.vram_cs = 0; u_if.vram_addr = '0; u_if.cache_inv = 0;
    u_if.sdram_ack = 0; u_if.sdram_rdy = 0; u_if.sdram_din = '0;
    w_if.vram_cs = 0; w_if.vram_addr = '0; w_if.cache_inv = 0;
    w_if.sdram_ack = 0; w_if.sdram_rdy = 0; w_if.sdram_din = '0;

    // reset state
    #2;
    chk("rst_ok",    32'(u_if.vram_ok),    32'd0);
    chk("rst_data",  32'(u_if.vram_data),  32'd0);
    chk("rst_req",   32'(u_if.sdram_req),  32'd0);
    chk("rst_saddr", 32'(u_if.sdram_addr), 32'd0);
    #20;
    @(negedge clk) rst_n = 1'b1;
    step();

    // miss then hit on the odd word of the same line
    u_if.vram_cs = 1; u_if.vram_addr = 18'h00100;
    step();
    chk("mh_stale", 32'(u_if.vram_ok), 32'd0);
    wait_req(22'h10_0100);
    do_ack(3, 0, '0);
    do_rdy(5, 0, 32'hBEEF_1234);
    chk("mh_lat", 32'(u_if.vram_ok), 32'd0);
    step();
    chk("mh_ok",   32'(u_if.vram_ok),   32'd1);
    chk("mh_data", 32'(u_if.vram_data), 32'h1234);
    base = nreq;
    u_if.vram_addr = 18'h00101;
    step();
    chk("hit_stale", 32'(u_if.vram_ok),   32'd0);
    chk("hit_hold",  32'(u_if.vram_data), 32'h1234);
    step();
    chk("hit_ok",    32'(u_if.vram_ok),   32'd1);
    chk("hit_data",  32'(u_if.vram_data), 32'hBEEF);
    chk("hit_noreq", 32'(nreq - base),    32'd0);
    chk("hit_reqlo", 32'(u_if.sdram_req), 32'd0);

    // ack and rdy in the same cycle
    u_if.vram_addr = 18'h00300;
    step();
    chk("co_stale", 32'(u_if.vram_ok), 32'd0);
    wait_req(22'h10_0300);
    do_ack(1, 1, 32'hCAFE_F00D);
    step();
    chk("co_ok",   32'(u_if.vram_ok),   32'd1);
    chk("co_data", 32'(u_if.vram_data), 32'hF00D);

    // address change while the fetch is in flight
    u_if.vram_addr = 18'h00200;
    step();
    wait_req(22'h10_0200);
    do_ack(0, 0, '0);
    u_if.vram_addr = 18'h00400;
    step();
    chk("mf_wait", 32'(u_if.vram_ok), 32'd0);
    do_rdy(1, 0, 32'h2222_1111);
    chk("mf_fill", 32'(u_if.vram_ok), 32'd0);
    step();
    chk("mf_after", 32'(u_if.vram_ok), 32'd0);
    wait_req(22'h10_0400);
    do_ack(0, 0, '0);
    do_rdy(0, 0, 32'h4444_3333);
    chk("mf_lat", 32'(u_if.vram_ok), 32'd0);
    step();
    chk("mf_ok",   32'(u_if.vram_ok),   32'd1);
    chk("mf_data", 32'(u_if.vram_data), 32'h3333);

    // invalidate while waiting for rdy: line stored invalid, refetched
    u_if.vram_addr = 18'h00500;
    step();
    wait_req(22'h10_0500);
    do_ack(0, 0, '0);
    u_if.cache_inv = 1;
    step();
    u_if.cache_inv = 0;
    do_rdy(1, 0, 32'h5555_AAAA);
    chk("iw_fill", 32'(u_if.vram_ok), 32'd0);
    step();
    chk("iw_ok0", 32'(u_if.vram_ok), 32'd0);
    wait_req(22'h10_0500);
    do_ack(0, 0, '0);
    do_rdy(0, 0, 32'h5151_A0A0);
    step();
    chk("iw_ok",   32'(u_if.vram_ok),   32'd1);
    chk("iw_data", 32'(u_if.vram_data), 32'hA0A0);

    // invalidate in IDLE on a hit, then cache_inv coincident with rdy
    u_if.cache_inv = 1;
    step();
    u_if.cache_inv = 0;
    chk("ii_ok1", 32'(u_if.vram_ok),   32'd1);
    step();
    chk("ii_ok0", 32'(u_if.vram_ok),   32'd0);
    chk("ii_req", 32'(u_if.sdram_req), 32'd1);
    wait_req(22'h10_0500);
    do_ack(0, 0, '0);
    do_rdy(0, 1, 32'h5252_B0B0);
    chk("ic_fill", 32'(u_if.vram_ok), 32'd0);
    step();
    chk("ic_ok0", 32'(u_if.vram_ok), 32'd0);
    wait_req(22'h10_0500);
    do_ack(0, 0, '0);
    do_rdy(0, 0, 32'h5353_C0C0);
    step();
    chk("ic_ok",   32'(u_if.vram_ok),   32'd1);
    chk("ic_data", 32'(u_if.vram_data), 32'hC0C0);

    // asynchronous reset in the middle of WAIT
    u_if.vram_addr = 18'h00000;
    step();
    wait_req(22'h10_0000);
    do_ack(0, 0, '0);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_ok",    32'(u_if.vram_ok),    32'd0);
    chk("ar_data",  32'(u_if.vram_data),  32'd0);
    chk("ar_req",   32'(u_if.sdram_req),  32'd0);
    chk("ar_saddr", 32'(u_if.sdram_addr), 32'd0);
    #2 rst_n = 1'b1;
    step();
    wait_req(22'h10_0000);
    do_ack(2, 0, '0);
    do_rdy(1, 0, 32'h0F0F_0A0A);
    step();
    chk("ar_rd_ok",   32'(u_if.vram_ok),   32'd1);
    chk("ar_rd_data", 32'(u_if.vram_data), 32'h0A0A);

    // 22-bit wrap of offset + address
    w_if.vram_cs = 1; w_if.vram_addr = 18'h00002;
    step();
    step();
    chk("wrap_req",  32'(w_if.sdram_req),  32'd1);
    chk("wrap_addr", 32'(w_if.sdram_addr), 32'h00_0000);

    // top VRAM word
    u_if.vram_addr = 18'h3FFFF;
    step();
    wait_req(22'h13_FFFE);
    do_ack(0, 0, '0);
    do_rdy(0, 0, 32'h7777_6666);
    step();
    chk("top_ok",   32'(u_if.vram_ok),   32'd1);
    chk("top_data", 32'(u_if.vram_data), 32'h7777);

    // palette sweep: 4096 sequential reads, one fetch per even word
    u_if.vram_cs = 0;
    step();
    u_if.cache_inv = 1;
    step();
    u_if.cache_inv = 0;
    step();
    base = nreq;
    for (int a = 0; a < 4096; a++) begin
      u_if.vram_cs = 1;
      u_if.vram_addr = 18'(a);
      step();
      chk("sw_stale", 32'(u_if.vram_ok), 32'd0);
      if (a % 2 == 0) begin
        wait_req(22'h10_0000 + 22'(a));
        do_ack(1, 0, '0);
        do_rdy(1, 0, {mw(a + 1), mw(a)});
      end
      wait_ok("sw_data", mw(a));
    end
    step();
    step();
    chk("sw_nreq", 32'(nreq - base), 32'd2048);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
